// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the multi-byte ALU sequencer.
//   BYTE_W         - width of one ALU pass
//   OP_ADD..OP_SHR - 3-bit opcodes, identical to the ALU select encoding
//   state_e        - sequencer states IDLE/PASS/FIX/DONE
package alu_seq_pkg;
  localparam int BYTE_W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {IDLE, PASS, FIX, DONE} state_e;
endpackage

// File: rtl/alu_seq_carry.sv
// alu_seq_carry: per-byte carry/borrow rule for the sequencer (combinational).
//   op      - current opcode (only add/sub produce a nonzero bit)
//   alu_a   - ALU operand a as driven this cycle
//   alu_b   - ALU operand b as driven this cycle
//   alu_out - ALU result for this cycle
//   fix     - 1 during the +/-1 fix-up pass, 0 during the main byte pass
//   c       - carry (add) or borrow (sub) produced by this pass alone
// The caller ORs the main-pass bit with the fix-pass bit; a byte can only
// carry out of one of the two passes, never both.
module alu_seq_carry
  import alu_seq_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [BYTE_W-1:0] alu_a,
  input  logic [BYTE_W-1:0] alu_b,
  input  logic [BYTE_W-1:0] alu_out,
  input  logic              fix,
  output logic              c
);
  always_comb begin
    c = 1'b0;
    if (op == OP_ADD)
      c = fix ? (alu_out == '0) : (alu_out < alu_a);  // wrap-around means carry
    else if (op == OP_SUB)
      c = fix ? (alu_a == '0) : (alu_a < alu_b);
  end
endmodule

// File: rtl/alu_seq_driver.sv
// alu_seq_driver: drives an 8-bit combinational ALU byte-by-byte to perform
// an NBYTES-wide operation, inserting +/-1 fix-up passes for carry/borrow.
//   clk, rst_n            - clock, synchronous active-low reset
//   req_valid/req_ready   - request handshake; req_op/req_a/req_b operands
//   rsp_valid/rsp_ready   - response handshake; rsp_data and z/n/c flags
//   rsp_v                 - signed overflow, present only with ALU_SEQ_OVF_EN
//   alu_a/alu_b/alu_s     - registered drive to the ALU
//   alu_out               - ALU result, combinational from alu_a/b/s
// Optional feature macro: ALU_SEQ_OVF_EN (adds rsp_v).
module alu_seq_driver
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 2,
  localparam int W = 8 * NBYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [W-1:0]      req_a,
  input  logic [W-1:0]      req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_z,
  output logic              rsp_n,
  output logic              rsp_c,
`ifdef ALU_SEQ_OVF_EN
  output logic              rsp_v,
`endif
  output logic [BYTE_W-1:0] alu_a,
  output logic [BYTE_W-1:0] alu_b,
  output logic [2:0]        alu_s,
  input  logic [BYTE_W-1:0] alu_out
);
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nx;
  logic               carry_q, carry_d;    // carry/borrow into the current byte
  logic               pass_c_q, pass_c_d;  // main-pass carry held across FIX
  logic               shin_q, shin_d;      // bit shifted into the current byte
  logic [BYTE_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]         alu_s_q, alu_s_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_data_q, rsp_data_d;
  logic               rsp_z_q, rsp_z_d, rsp_n_q, rsp_n_d, rsp_c_q, rsp_c_d;
`ifdef ALU_SEQ_OVF_EN
  logic               rsp_v_q, rsp_v_d;
`endif

  logic               cbit, adv, go_fix, last, arith;
  logic [BYTE_W-1:0]  byte_v, a_byte;

  alu_seq_carry u_carry (
    .op     (op_q),
    .alu_a  (alu_a_q),
    .alu_b  (alu_b_q),
    .alu_out(alu_out),
    .fix    (state_q == FIX),
    .c      (cbit)
  );

  assign req_ready = rst_n && (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_n     = rsp_n_q;
  assign rsp_c     = rsp_c_q;
`ifdef ALU_SEQ_OVF_EN
  assign rsp_v     = rsp_v_q;
`endif
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;

  always_comb begin
    state_d = state_q;  op_d = op_q;  a_d = a_q;  b_d = b_q;  res_d = res_q;
    idx_d = idx_q;  carry_d = carry_q;  pass_c_d = pass_c_q;  shin_d = shin_q;
    rsp_valid_d = rsp_valid_q;  rsp_data_d = rsp_data_q;
    rsp_z_d = rsp_z_q;  rsp_n_d = rsp_n_q;  rsp_c_d = rsp_c_q;
`ifdef ALU_SEQ_OVF_EN
    rsp_v_d = rsp_v_q;
`endif
    // ALU is parked at zero/add unless a pass is scheduled below
    alu_a_d = '0;  alu_b_d = '0;  alu_s_d = OP_ADD;
    adv = 1'b0;  go_fix = 1'b0;
    byte_v = alu_out;
    a_byte = a_q[BYTE_W*idx_q +: BYTE_W];
    arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
    // shr walks MSB->LSB, everything else LSB->MSB
    idx_nx = (op_q == OP_SHR) ? idx_q - 1'b1 : idx_q + 1'b1;
    last   = (op_q == OP_SHR) ? (idx_q == '0) : (idx_q == IDX_W'(NBYTES - 1));

    unique case (state_q)
      IDLE: if (req_valid && req_ready) begin
        state_d = PASS;  op_d = req_op;  a_d = req_a;  b_d = req_b;
        idx_d = (req_op == OP_SHR) ? IDX_W'(NBYTES - 1) : '0;
        carry_d = 1'b0;  pass_c_d = 1'b0;  shin_d = 1'b0;
        alu_a_d = req_a[BYTE_W*idx_d +: BYTE_W];
        alu_b_d = req_b[BYTE_W*idx_d +: BYTE_W];
        alu_s_d = req_op;
      end
      PASS: begin
        if (op_q == OP_SHL) begin
          byte_v = alu_out | {7'b0, shin_q};
          shin_d = a_byte[BYTE_W-1];
        end else if (op_q == OP_SHR) begin
          byte_v = alu_out | {shin_q, 7'b0};
          shin_d = a_byte[0];
        end
        res_d[BYTE_W*idx_q +: BYTE_W] = byte_v;
        // An incoming carry/borrow is applied as a separate +/-1 pass
        if (arith && carry_q) begin
          pass_c_d = cbit;
          go_fix   = 1'b1;
        end else begin
          carry_d = cbit;
          adv     = 1'b1;
        end
      end
      FIX: begin
        res_d[BYTE_W*idx_q +: BYTE_W] = alu_out;
        carry_d = pass_c_q | cbit;
        adv     = 1'b1;
      end
      DONE: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (go_fix) begin
      state_d = FIX;
      alu_a_d = byte_v;
      alu_b_d = 8'h01;
      alu_s_d = op_q;
    end

    if (adv) begin
      if (last) begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = res_d;
        rsp_z_d     = (res_d == '0);
        rsp_n_d     = res_d[W-1];
        rsp_c_d     = arith ? carry_d :
                      ((op_q == OP_SHL) || (op_q == OP_SHR)) ? shin_d : 1'b0;
`ifdef ALU_SEQ_OVF_EN
        rsp_v_d = 1'b0;
        if (op_q == OP_ADD)
          rsp_v_d = (a_q[W-1] == b_q[W-1]) && (res_d[W-1] != a_q[W-1]);
        else if (op_q == OP_SUB)
          rsp_v_d = (a_q[W-1] != b_q[W-1]) && (res_d[W-1] != a_q[W-1]);
`endif
      end else begin
        state_d = PASS;
        idx_d   = idx_nx;
        alu_a_d = a_q[BYTE_W*idx_nx +: BYTE_W];
        alu_b_d = b_q[BYTE_W*idx_nx +: BYTE_W];
        alu_s_d = op_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;  op_q <= '0;  a_q <= '0;  b_q <= '0;  res_q <= '0;
      idx_q <= '0;  carry_q <= 1'b0;  pass_c_q <= 1'b0;  shin_q <= 1'b0;
      alu_a_q <= '0;  alu_b_q <= '0;  alu_s_q <= '0;
      rsp_valid_q <= 1'b0;  rsp_data_q <= '0;
      rsp_z_q <= 1'b0;  rsp_n_q <= 1'b0;  rsp_c_q <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      rsp_v_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  op_q <= op_d;  a_q <= a_d;  b_q <= b_d;  res_q <= res_d;
      idx_q <= idx_d;  carry_q <= carry_d;  pass_c_q <= pass_c_d;  shin_q <= shin_d;
      alu_a_q <= alu_a_d;  alu_b_q <= alu_b_d;  alu_s_q <= alu_s_d;
      rsp_valid_q <= rsp_valid_d;  rsp_data_q <= rsp_data_d;
      rsp_z_q <= rsp_z_d;  rsp_n_q <= rsp_n_d;  rsp_c_q <= rsp_c_d;
`ifdef ALU_SEQ_OVF_EN
      rsp_v_q <= rsp_v_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench for alu_seq_driver (NBYTES=2) with a behavioural 8-bit ALU.
module tb_alu_seq_driver;
  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0]  req_op, alu_s;
  logic [15:0] req_a, req_b, rsp_data;
  logic        rsp_z, rsp_n, rsp_c;
`ifdef ALU_SEQ_OVF_EN
  logic        rsp_v;
`endif
  logic [7:0]  alu_a, alu_b, alu_out;
  int          vec = 0, errs = 0;

  always #5 clk = ~clk;

  // 8-bit combinational ALU the sequencer drives
  always_comb begin
    case (alu_s)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a - alu_b;
      3'b010: alu_out = alu_a & alu_b;
      3'b011: alu_out = alu_a | alu_b;
      3'b100: alu_out = ~alu_a;
      3'b101: alu_out = alu_a ^ alu_b;
      3'b110: alu_out = alu_a << 1;
      default: alu_out = alu_a >> 1;
    endcase
  end

  alu_seq_driver #(.NBYTES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_n(rsp_n),
    .rsp_c(rsp_c),
`ifdef ALU_SEQ_OVF_EN
    .rsp_v(rsp_v),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out));

  // Issue one request; returns at the negedge where rsp_valid is first seen.
  // lat = clock edges from the accepting edge to rsp_valid (50 = timed out).
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, b, output int lat);
    @(negedge clk); req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk); req_valid = 1'b0; lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    vec++; if (rsp_data !== 16'h0) begin errs++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
    vec++; if ({rsp_z, rsp_n, rsp_c} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {rsp_z, rsp_n, rsp_c}); end
    vec++; if ({alu_a, alu_b, alu_s} !== 19'h0) begin errs++; $display("FAIL reset_alu got %h/%h/%h want 0", alu_a, alu_b, alu_s); end
    vec++; if (req_ready !== 1'b0) begin errs++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
`ifdef ALU_SEQ_OVF_EN
    vec++; if (rsp_v !== 1'b0) begin errs++; $display("FAIL reset_rsp_v got %b want 0", rsp_v); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL idle_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_add;
    int lat;
    do_op(3'b000, 16'h00FF, 16'h0001, lat);
    vec++; if (lat !== 4) begin errs++; $display("FAIL add1_latency got %0d want 4", lat); end
    vec++; if (rsp_data !== 16'h0100) begin errs++; $display("FAIL add1_data got %h want 0100", rsp_data); end
    vec++; if ({rsp_z, rsp_n, rsp_c} !== 3'b000) begin errs++; $display("FAIL add1_znc got %b want 000", {rsp_z, rsp_n, rsp_c}); end
    @(negedge clk);
    vec++; if ({rsp_valid, req_ready} !== 2'b01) begin errs++; $display("FAIL add1_release got %b want 01", {rsp_valid, req_ready}); end
    do_op(3'b000, 16'hFFFF, 16'h0001, lat);
    vec++; if (lat !== 4) begin errs++; $display("FAIL add2_latency got %0d want 4", lat); end
    vec++; if (rsp_data !== 16'h0000) begin errs++; $display("FAIL add2_data got %h want 0000", rsp_data); end
    vec++; if ({rsp_z, rsp_n, rsp_c} !== 3'b101) begin errs++; $display("FAIL add2_znc got %b want 101", {rsp_z, rsp_n, rsp_c}); end
`ifdef ALU_SEQ_OVF_EN
    vec++; if (rsp_v !== 1'b0) begin errs++; $display("FAIL add2_v got %b want 0", rsp_v); end
`endif
    @(negedge clk);
  endtask

  task automatic test_sub;
    int lat;
    do_op(3'b001, 16'h0000, 16'h0001, lat);
    vec++; if (lat !== 4) begin errs++; $display("FAIL sub1_latency got %0d want 4", lat); end
    vec++; if (rsp_data !== 16'hFFFF) begin errs++; $display("FAIL sub1_data got %h want ffff", rsp_data); end
    vec++; if ({rsp_z, rsp_n, rsp_c} !== 3'b011) begin errs++; $display("FAIL sub1_znc got %b want 011", {rsp_z, rsp_n, rsp_c}); end
    @(negedge clk);
    do_op(3'b001, 16'h8000, 16'h0001, lat);
    vec++; if (rsp_data !== 16'h7FFF) begin errs++; $display("FAIL sub2_data got %h want 7fff", rsp_data); end
    vec++; if ({rsp_z, rsp_n, rsp_c} !== 3'b000) begin errs++; $display("FAIL sub2_znc got %b want 000", {rsp_z, rsp_n, rsp_c}); end
`ifdef ALU_SEQ_OVF_EN
    vec++; if (rsp_v !== 1'b1) begin errs++; $display("FAIL sub2_v got %b want 1", rsp_v); end
`endif
    @(negedge clk);
  endtask

  task automatic test_shift_logic;
    int lat;
    do_op(3'b110, 16'h8080, 16'h0000, lat);
    vec++; if (lat !== 3) begin errs++; $display("FAIL shl_latency got %0d want 3", lat); end
    vec++; if (rsp_data !== 16'h0100) begin errs++; $display("FAIL shl_data got %h want 0100", rsp_data); end
    vec++; if (rsp_c !== 1'b1) begin errs++; $display("FAIL shl_c got %b want 1", rsp_c); end
    @(negedge clk);
    do_op(3'b111, 16'h0101, 16'h0000, lat);
    vec++; if (lat !== 3) begin errs++; $display("FAIL shr_latency got %0d want 3", lat); end
    vec++; if (rsp_data !== 16'h0080) begin errs++; $display("FAIL shr_data got %h want 0080", rsp_data); end
    vec++; if (rsp_c !== 1'b1) begin errs++; $display("FAIL shr_c got %b want 1", rsp_c); end
    @(negedge clk);
    do_op(3'b101, 16'hF0F0, 16'hFFFF, lat);
    vec++; if (rsp_data !== 16'h0F0F) begin errs++; $display("FAIL xor_data got %h want 0f0f", rsp_data); end
    vec++; if ({rsp_z, rsp_n, rsp_c} !== 3'b000) begin errs++; $display("FAIL xor_znc got %b want 000", {rsp_z, rsp_n, rsp_c}); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat;
    rsp_ready = 1'b0;
    do_op(3'b000, 16'h00FF, 16'h0001, lat);
    vec++; if (lat !== 4) begin errs++; $display("FAIL bp_latency got %0d want 4", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++;
      if ({rsp_valid, req_ready, rsp_data, rsp_z, rsp_n, rsp_c} !== {2'b10, 16'h0100, 3'b000}) begin
        errs++; $display("FAIL bp_hold%0d got v=%b rdy=%b d=%h znc=%b want v=1 rdy=0 d=0100 znc=000",
                         i, rsp_valid, req_ready, rsp_data, {rsp_z, rsp_n, rsp_c});
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vec++; if ({rsp_valid, req_ready} !== 2'b01) begin errs++; $display("FAIL bp_release got %b want 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_reset_midop;
    int lat;
    @(negedge clk); req_valid = 1'b1; req_op = 3'b000; req_a = 16'h00FF; req_b = 16'h0001;
    @(negedge clk); req_valid = 1'b0;
    vec++; if (alu_a !== 8'hFF) begin errs++; $display("FAIL midop_pass_alu_a got %h want ff", alu_a); end
    rst_n = 1'b0;
    @(negedge clk);
    vec++; if ({rsp_valid, alu_s, alu_a, req_ready} !== 13'h0) begin
      errs++; $display("FAIL midop_reset got v=%b s=%b a=%h rdy=%b want all 0", rsp_valid, alu_s, alu_a, req_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL midop_stale%0d got %b want 0", i, rsp_valid); end
    end
    do_op(3'b001, 16'h8000, 16'h0001, lat);
    vec++; if (lat !== 4) begin errs++; $display("FAIL midop_after_latency got %0d want 4", lat); end
    vec++; if (rsp_data !== 16'h7FFF) begin errs++; $display("FAIL midop_after_data got %h want 7fff", rsp_data); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_shift_logic;
    test_backpressure;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
